// File: rtl/mips_prog_loader_pkg.sv
// Shared types and constants for the MIPS_32 program loader.
//   state_e        : top-level loader sequence
//   dump_phase_e   : per-register sub-sequence while dumping
//   hdr_count_ok() : accepts a header word count against the imem depth
package mips_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int CNT_W          = HDR_BYTES * 8;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    LOAD,
    RUN,
    DUMP,
    DONE,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    DPH_ADDR,
    DPH_CAPT,
    DPH_EMIT
  } dump_phase_e;

  function automatic logic hdr_count_ok(input logic [CNT_W-1:0] n, input int unsigned addr_w);
    return (n != '0) && (32'(n) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Bus bundle between the loader, the host byte link and the MIPS_32 core.
//   host in : in_valid/in_data -> in_ready
//   host out: out_valid/out_data <- out_ready
//   core    : imem_we/imem_addr/imem_wdata, core_reset, core_halted,
//             rf_raddr -> rf_rdata (one cycle later)
//   status  : busy, done, err
// master = loader side, slave = host/core side.
interface mips_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              core_halted;
  logic [4:0]        rf_raddr;
  logic [31:0]       rf_rdata;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  in_valid, in_data, core_halted, rf_rdata, out_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, core_reset,
           rf_raddr, out_valid, out_data, busy, done, err
  );

  modport slave (
    output in_valid, in_data, core_halted, rf_rdata, out_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_reset,
           rf_raddr, out_valid, out_data, busy, done, err
  );
endinterface

// File: rtl/mips_byte_ser.sv
// Word-to-byte serializer: load a 32-bit word, emit it MSB first over a
// valid/ready stream. last is high on the handshake of the fourth byte.
//   clk, rst      : clock, async active-high reset
//   load, word    : capture a new word (only while idle)
//   out_valid/out_data/out_ready : byte stream
//   last          : fourth byte transferring this cycle
module mips_byte_ser
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        last
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (load) begin
      word_d = word;
      cnt_d  = 2'd0;
      vld_d  = 1'b1;
    end else if (vld_q && out_ready) begin
      word_d = {word_q[23:0], 8'h00};
      cnt_d  = cnt_q + 2'd1;
      if (cnt_q == 2'(BYTES_PER_WORD - 1)) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // Byte is taken from the top of a register, so it cannot change while stalled.
  assign out_valid = vld_q;
  assign out_data  = word_q[31:24];
  assign last      = vld_q && out_ready && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_prog_loader.sv
// MIPS_32 program loader / register dumper.
// Receives a 16-bit big-endian word count N followed by N instruction words
// (MSB first), writes them to imem while the core is held in reset, releases
// the core, waits for HLT (bounded by TIMEOUT), then streams R0..R(DUMP_REGS-1)
// out as bytes, MSB first.
//   clk1, rst : clock, async active-high reset
//   bus       : mips_prog_loader_if.master (host streams, imem port,
//               core control, rf debug port, status)
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DUMP_REGS = 6,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk1,
  input  logic                rst,
  mips_prog_loader_if.master  bus
);

  state_e            state_q, state_d;
  dump_phase_e       dph_q, dph_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       shift_q, shift_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_reset_q, core_reset_d;
  logic [31:0]       timer_q, timer_d;
  logic [4:0]        raddr_q, raddr_d;

  logic in_ready_c, busy_c, done_c, err_c;
  logic in_xfer;
  logic ser_load, ser_last;

  assign in_xfer = bus.in_valid && in_ready_c;

  // State register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= HDR0;
      dph_q        <= DPH_ADDR;
      n_q          <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      shift_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      timer_q      <= '0;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      dph_q        <= dph_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      shift_q      <= shift_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      timer_q      <= timer_d;
      raddr_q      <= raddr_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    dph_d    = dph_q;
    n_d      = n_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    raddr_d  = raddr_q;
    ser_load = 1'b0;

    case (state_q)
      HDR0: begin
        if (in_xfer) begin
          n_d     = {bus.in_data, 8'h00};
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (in_xfer) begin
          n_d = {n_q[15:8], bus.in_data};
          if (hdr_count_ok(n_d, ADDR_W)) begin
            state_d = LOAD;
            widx_d  = '0;
            bidx_d  = '0;
          end else begin
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        if (in_xfer) begin
          shift_d = {shift_q[15:0], bus.in_data};
          bidx_d  = bidx_q + 2'd1;
          if (bidx_q == 2'(BYTES_PER_WORD - 1)) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = {shift_q, bus.in_data};
            widx_d  = widx_q + 16'd1;
            // The final write cycle happens in RUN, where the core is still held.
            if (widx_q == n_q - 16'd1) begin
              state_d = RUN;
              timer_d = '0;
            end
          end
        end
      end
      RUN: begin
        if (bus.core_halted) begin
          state_d = DUMP;
          dph_d   = DPH_ADDR;
          raddr_d = '0;
        end else if (timer_q == 32'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      DUMP: begin
        case (dph_q)
          DPH_ADDR: dph_d = DPH_CAPT;
          DPH_CAPT: begin
            ser_load = 1'b1;
            dph_d    = DPH_EMIT;
          end
          DPH_EMIT: begin
            if (ser_last) begin
              if (raddr_q == 5'(DUMP_REGS - 1)) begin
                state_d = DONE;
              end else begin
                raddr_d = raddr_q + 5'd1;
                dph_d   = DPH_ADDR;
              end
            end
          end
          default: dph_d = DPH_ADDR;
        endcase
      end
      default: ;
    endcase

    // Release lags RUN entry by one cycle so the last imem write sees reset held.
    core_reset_d = !((state_q inside {RUN, DUMP, DONE}) && (state_d != ERR));
  end

  // Outputs decoded from state
  always_comb begin
    in_ready_c = state_q inside {HDR0, HDR1, LOAD};
    busy_c     = !(state_q inside {HDR0, DONE, ERR});
    done_c     = (state_q == DONE);
    err_c      = (state_q == ERR);
  end

  mips_byte_ser u_ser (
    .clk       (clk1),
    .rst       (rst),
    .load      (ser_load),
    .word      (bus.rf_rdata),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .last      (ser_last)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_reset = core_reset_q;
  assign bus.rf_raddr   = raddr_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.err        = err_c;

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
Hardware front end for MIPS_32 that replaces hierarchical memory preloading and register peeking. It accepts a byte stream carrying a program, writes it into instruction memory while holding the core in reset, then releases the core. On HLT it reads back the low registers and streams them out as bytes. It sits between a host byte link (UART/FIFO) and the core's imem write port and register-file debug read port.

Parameters:
ADDR_W, 10, instruction memory word-address width; max program depth = 2**ADDR_W words
DUMP_REGS, 6, number of registers dumped (R0..R(DUMP_REGS-1)), range 1..32
TIMEOUT, 4096, clk1 cycles allowed in RUN before error

Ports:
clk1  in  1  single clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  host byte valid
in_data  in  8  host byte
in_ready  out  1  loader accepts byte (combinational from state only)
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  instruction word
core_reset  out  1  holds core: pc=0, halted=0, taken_branch=0
core_halted  in  1  core HLT flag
rf_raddr  out  5  register-file debug read address
rf_rdata  in  32  register data, valid 1 cycle after rf_raddr
out_valid  out  1  dump byte valid
out_data  out  8  dump byte
out_ready  in  1  host accepts dump byte
busy  out  1  high in every state except HDR0, DONE, ERR
done  out  1  dump complete
err  out  1  protocol/timeout error

Behaviour:
- Reset (async, takes effect immediately): state=HDR0, core_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, rf_raddr=0, out_valid=0, out_data=0, busy=0, done=0, err=0. in_ready=1 once state=HDR0.
- Byte transfer occurs on a clk1 edge with valid&&ready (both streams).
- HDR0/HDR1: capture word count N as 16 bits, big-endian (HDR0=MSB).
- After HDR1: N==0 or N>2**ADDR_W -> ERR; else -> LOAD, word index=0, byte index=0.
- LOAD: in_ready=1. Bytes shift into 32-bit register MSB first. On the 4th byte: the next cycle has imem_we=1 for exactly one cycle with imem_addr=word index, imem_wdata=assembled word. Word index then increments. A byte accepted during the write cycle is legal and starts the next word.
- After the write of word N-1 -> RUN. in_ready=0 from RUN onward.
- RUN: core_reset=0 (registered, drops first cycle in RUN). Cycle counter from 0. core_halted==1 -> DUMP. Counter reaching TIMEOUT first -> ERR.
- DUMP: per register r=0..DUMP_REGS-1:
  - drive rf_raddr=r one cycle
  - capture rf_rdata next cycle
  - emit 4 bytes MSB first
- out_data/out_valid hold stable while out_valid && !out_ready. out_valid never drops without a handshake.
- After the last byte -> DONE: done=1 and sticky, core stays released. Remain until rst.
- ERR: err=1 sticky, core_reset=1, in_ready=0, out_valid=0. Remain until rst.
- Reset mid-LOAD or mid-DUMP: partial word discarded, partial output byte dropped, core re-held. Memory contents already written are not cleared.
- No accesses to imem while core_reset=0.

Decomposition:
- Package mips_loader_pkg:
  - state enum {HDR0,HDR1,LOAD,RUN,DUMP,DONE,ERR}
  - BYTES_PER_WORD=4
  - HDR_BYTES=2
  - count width 16
- Sub-module mips_byte_ser: loads a 32-bit word, emits 4 bytes MSB first over valid/ready, raises a last-byte flag. Used by the DUMP state.

Test Plan:
- Load N=9 (00 09, then 2801000a 28020014 28030019 0ce77800 0ce77800 00222000 0ce77800 00832800 fc000000 as bytes) -> 9 imem_we pulses; addr 5 carries 0x00222000; core_reset falls after 9th write; dump = 00000000 0000000a 00000014 00000019 0000001e 00000037; done=1.
- Same program, out_ready toggled 1/0 every cycle plus a 10-cycle stall -> identical 24 byte sequence; out_data stable during stalls.
- Header 00 00, and separately header 04 01 with ADDR_W=10 -> err=1, no imem_we, core_reset stays 1, in_ready=0.
- Program without HLT (N=1, 0ce77800) -> err=1 exactly TIMEOUT cycles after RUN entry; no dump bytes.
- rst pulse after 2 bytes of word 3 -> all outputs at reset values asynchronously. A reload of N=9 then produces the correct dump.
- in_valid gapped randomly during LOAD -> imem writes identical to the gap-free case.
